// File: rtl/exmem_pkg.sv
// Shared MMIO map for exmem_mmio: register offsets and KEY_STATUS bit layout.
// CPU software uses the same constants to address the keyboard and framebuffer.
package exmem_pkg;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  function automatic int key_data_addr(input int aw);
    return (1 << aw) - 1;
  endfunction

  function automatic int key_status_addr(input int aw);
    return (1 << aw) - 2;
  endfunction

  function automatic int fb_base(input int aw, input int fb_words);
    return (1 << aw) - 2 - fb_words;
  endfunction

endpackage

// File: rtl/exmem_mmio_key_fifo.sv
// Keyboard byte FIFO: wrap-around pointers with one extra bit to tell full from empty,
// simultaneous push/pop, and a sticky overflow flag.
module key_fifo #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  input  logic          i_clr_ovf,
  output logic [7:0]    o_head,
  output logic [PW:0]   o_count,
  output logic          o_empty,
  output logic          o_overflow
);

  logic [7:0]  r_mem [DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic        r_overflow;

  logic [PW:0] w_count;
  logic        w_full;
  logic        w_do_pop;
  logic        w_do_push;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == (PW+1)'(DEPTH));
  assign o_empty   = (w_count == '0);
  // A pop frees a slot in the same cycle, so a push while full is still accepted.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // NOTE: storage has no reset; resetting the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && w_full && !w_do_pop) r_overflow <= 1'b1;
      else if (i_clr_ovf)                r_overflow <= 1'b0;
    end
  end

  assign o_head     = r_mem[r_rd_ptr[PW-1:0]];
  assign o_count    = w_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/exmem_mmio.sv
// Dual-port data RAM with memory-mapped keyboard FIFO/status at the top two words
// and a framebuffer window snapshotted into `bitmap` on each frame_sync pulse.
module exmem_mmio
  import exmem_pkg::*;
#(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 10,
  parameter int    FB_WORDS   = 20,
  parameter int    KEY_DEPTH  = 8,
  parameter string INIT_FILE  = "",
  localparam int   CW         = $clog2(KEY_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_WIDTH-1:0]          din1,
  input  logic [DATA_WIDTH-1:0]          din2,
  input  logic [ADDR_WIDTH-1:0]          addr1,
  input  logic [ADDR_WIDTH-1:0]          addr2,
  input  logic                           wen1,
  input  logic                           wen2,
  input  logic                           ren1,
  input  logic                           ren2,
  input  logic [7:0]                     key_data,
  input  logic                           key_strobe,
  input  logic                           frame_sync,
  output logic [DATA_WIDTH-1:0]          dout1,
  output logic [DATA_WIDTH-1:0]          dout2,
  output logic [FB_WORDS*DATA_WIDTH-1:0] bitmap,
  output logic [CW-1:0]                  key_count,
  output logic                           key_overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] KEY_DATA_A   = ADDR_WIDTH'(key_data_addr(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] KEY_STATUS_A = ADDR_WIDTH'(key_status_addr(ADDR_WIDTH));
  localparam int                    FB_BASE      = fb_base(ADDR_WIDTH, FB_WORDS);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout1, r_dout2;
  logic [FB_WORDS*DATA_WIDTH-1:0] r_bitmap;
  logic r_sync1, r_sync2, r_sync_prev;

  logic w_we1, w_we2, w_key_edge, w_pop, w_clr_ovf;
  logic w_empty, w_overflow;
  logic [7:0] w_head;
  logic [CW-1:0] w_count;
  logic [DATA_WIDTH-1:0] w_status, w_key_word;

  assign w_we1 = wen1 && addr1 != KEY_DATA_A && addr1 != KEY_STATUS_A;
  assign w_we2 = wen2 && addr2 != KEY_DATA_A && addr2 != KEY_STATUS_A;
  assign w_clr_ovf = (wen1 && addr1 == KEY_STATUS_A) || (wen2 && addr2 == KEY_STATUS_A);

  // Write-first view of a RAM word: port 1 beats port 2 on a shared address.
  function automatic logic [DATA_WIDTH-1:0] wf_read(input logic [ADDR_WIDTH-1:0] a);
    wf_read = r_mem[a];
    if (w_we2 && addr2 == a) wf_read = din2;
    if (w_we1 && addr1 == a) wf_read = din1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_we2) r_mem[addr2] <= din2;
    if (w_we1) r_mem[addr1] <= din1;
  end

  assign w_key_edge = r_sync2 & ~r_sync_prev;
  assign w_pop      = (ren1 && addr1 == KEY_DATA_A) || (ren2 && addr2 == KEY_DATA_A);

  key_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_push     (w_key_edge),
    .i_data     (key_data),
    .i_pop      (w_pop),
    .i_clr_ovf  (w_clr_ovf),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
    w_status[STAT_OVF_BIT]   = w_overflow;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_key_word = '0;
    if (!w_empty) w_key_word[7:0] = w_head;
  end

  function automatic logic [DATA_WIDTH-1:0] rd_mux(input logic [ADDR_WIDTH-1:0] a);
    if (a == KEY_DATA_A)        rd_mux = w_key_word;
    else if (a == KEY_STATUS_A) rd_mux = w_status;
    else                        rd_mux = wf_read(a);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout1     <= '0;
      r_dout2     <= '0;
      r_bitmap    <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= key_strobe;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_dout1     <= rd_mux(addr1);
      r_dout2     <= rd_mux(addr2);
      if (frame_sync) begin
        for (int i = 0; i < FB_WORDS; i++)
          r_bitmap[i*DATA_WIDTH +: DATA_WIDTH] <= wf_read(ADDR_WIDTH'(FB_BASE + i));
      end
    end
  end

  assign dout1        = r_dout1;
  assign dout2        = r_dout2;
  assign bitmap       = r_bitmap;
  assign key_count    = w_count;
  assign key_overflow = w_overflow;

endmodule

// File: tb/tb_exmem_mmio.sv
// Directed self-checking bench for exmem_mmio (KEY_DEPTH=4 so overflow is reachable).
module tb_exmem_mmio;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FBW = 20;
  localparam int KD = 4;
  localparam logic [AW-1:0] A_KDATA = 10'd1023;
  localparam logic [AW-1:0] A_KSTAT = 10'd1022;
  localparam int FB0 = 1002;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [DW-1:0] din1 = '0, din2 = '0;
  logic [AW-1:0] addr1 = '0, addr2 = '0;
  logic wen1 = 1'b0, wen2 = 1'b0, ren1 = 1'b0, ren2 = 1'b0;
  logic [7:0] key_data = '0;
  logic key_strobe = 1'b0, frame_sync = 1'b0;
  logic [DW-1:0] dout1, dout2;
  logic [FBW*DW-1:0] bitmap;
  logic [2:0] key_count;
  logic key_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [FBW*DW-1:0] exp_bm;
  logic [DW-1:0] q;

  exmem_mmio #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_WORDS(FBW), .KEY_DEPTH(KD)) dut (
    .clk(clk), .reset_n(reset_n), .din1(din1), .din2(din2), .addr1(addr1), .addr2(addr2),
    .wen1(wen1), .wen2(wen2), .ren1(ren1), .ren2(ren2), .key_data(key_data),
    .key_strobe(key_strobe), .frame_sync(frame_sync), .dout1(dout1), .dout2(dout2),
    .bitmap(bitmap), .key_count(key_count), .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FBW*DW-1:0] obs, input logic [FBW*DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr1 = a; din1 = d; wen1 = 1'b1;
    tick();
    wen1 = 1'b0;
  endtask

  task automatic rd1(input logic [AW-1:0] a, input logic r, output logic [DW-1:0] d);
    addr1 = a; ren1 = r;
    tick();
    d = dout1;
    ren1 = 1'b0; addr1 = '0;
  endtask

  task automatic key_send(input logic [7:0] b);
    key_data = b; key_strobe = 1'b1;
    repeat (4) tick();
    key_strobe = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (2) tick();
    check("reset_dout1", dout1, 0);
    check("reset_bitmap", bitmap, 0);
    check("reset_count", key_count, 0);
    check("reset_ovf", key_overflow, 0);
    reset_n = 1'b1;
    tick();

    // Same-edge write on port 1 seen by reads on both ports.
    addr1 = 10'd5; din1 = 16'hBEEF; wen1 = 1'b1; addr2 = 10'd5;
    tick();
    wen1 = 1'b0;
    check("wf_port2", dout2, 16'hBEEF);
    check("wf_port1", dout1, 16'hBEEF);
    addr2 = '0;

    addr1 = 10'd7; din1 = 16'h1111; wen1 = 1'b1;
    addr2 = 10'd7; din2 = 16'h2222; wen2 = 1'b1;
    tick();
    wen1 = 1'b0; wen2 = 1'b0; addr2 = '0;
    check("dual_wr_same_edge", dout1, 16'h1111);
    rd1(10'd7, 1'b0, q);
    check("dual_wr_readback", q, 16'h1111);

    // Keyboard FIFO basic push/pop.
    key_send(8'h41); key_send(8'h42); key_send(8'h43);
    check("count_3", key_count, 3);
    rd1(A_KDATA, 1'b0, q);
    check("peek_no_pop", q, 16'h0041);
    check("peek_count", key_count, 3);
    rd1(A_KDATA, 1'b1, q); check("pop_41", q, 16'h0041);
    rd1(A_KDATA, 1'b1, q); check("pop_42", q, 16'h0042);
    rd1(A_KDATA, 1'b1, q); check("pop_43", q, 16'h0043);
    rd1(A_KDATA, 1'b1, q); check("pop_empty", q, 16'h0000);
    rd1(A_KSTAT, 1'b0, q); check("status_empty", q, 16'h0001);
    check("count_0", key_count, 0);

    // Overflow: five strobes into a four-deep FIFO.
    for (int i = 0; i < 5; i++) key_send(8'h51 + 8'(i));
    check("count_full", key_count, 4);
    check("ovf_set", key_overflow, 1);
    rd1(A_KSTAT, 1'b0, q); check("status_full_ovf", q, 16'h0402);
    wr1(A_KSTAT, 16'hFFFF);
    check("ovf_cleared", key_overflow, 0);
    rd1(A_KSTAT, 1'b0, q); check("status_after_clr", q, 16'h0400);
    wr1(A_KDATA, 16'h00EE);
    check("kdata_write_ignored", key_count, 4);

    // Push while full coinciding with a port-2 pop.
    key_data = 8'h56; key_strobe = 1'b1;
    repeat (2) tick();
    addr2 = A_KDATA; ren2 = 1'b1;
    tick();
    ren2 = 1'b0; addr2 = '0;
    check("full_pushpop_dout2", dout2, 16'h0051);
    check("full_pushpop_count", key_count, 4);
    check("full_pushpop_ovf", key_overflow, 0);
    key_strobe = 1'b0;
    repeat (3) tick();

    // Both ports pop at once: one pop, same byte on each.
    addr1 = A_KDATA; ren1 = 1'b1; addr2 = A_KDATA; ren2 = 1'b1;
    tick();
    ren1 = 1'b0; ren2 = 1'b0; addr1 = '0; addr2 = '0;
    check("dual_pop_p1", dout1, 16'h0052);
    check("dual_pop_p2", dout2, 16'h0052);
    check("dual_pop_count", key_count, 3);
    rd1(A_KDATA, 1'b1, q); check("order_53", q, 16'h0053);
    rd1(A_KDATA, 1'b1, q); check("order_54", q, 16'h0054);
    rd1(A_KDATA, 1'b1, q); check("order_56", q, 16'h0056);
    check("drained", key_count, 0);

    // Framebuffer snapshot.
    for (int i = 0; i < FBW; i++) begin
      wr1(AW'(FB0 + i), 16'h00A0 + 16'(i));
      exp_bm[i*DW +: DW] = 16'h00A0 + 16'(i);
    end
    check("bitmap_before_sync", bitmap, 0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("bitmap_snap", bitmap, exp_bm);
    for (int i = 0; i < FBW; i++) wr1(AW'(FB0 + i), 16'h00F0 + 16'(i));
    check("bitmap_hold", bitmap, exp_bm);
    for (int i = 0; i < FBW; i++) exp_bm[i*DW +: DW] = 16'h00F0 + 16'(i);
    exp_bm[DW-1:0] = 16'h1234;
    addr1 = AW'(FB0); din1 = 16'h1234; wen1 = 1'b1; frame_sync = 1'b1;
    tick();
    wen1 = 1'b0; frame_sync = 1'b0;
    check("bitmap_same_edge_wr", bitmap, exp_bm);

    // Asynchronous reset with keys queued and a live bitmap.
    key_send(8'h61); key_send(8'h62); key_send(8'h63);
    rd1(10'd5, 1'b0, q);
    check("pre_reset_count", key_count, 3);
    reset_n = 1'b0;
    #1;
    check("rst_dout1", dout1, 0);
    check("rst_bitmap", bitmap, 0);
    check("rst_count", key_count, 0);
    check("rst_ovf", key_overflow, 0);
    tick();
    reset_n = 1'b1;
    tick();
    rd1(10'd5, 1'b0, q); check("ram_survives_reset", q, 16'hBEEF);
    rd1(A_KSTAT, 1'b0, q); check("status_after_reset", q, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
